cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among the result-producing units: ALU reservation stations, branch unit, and load/store queue.
- Each cycle it grants at most one pending result, round-robin, and drives a registered broadcast to the reorder buffer and all reservation stations.
- The ROB and RS tag-match logic consume the broadcast to mark entries ready and to capture operands.

---
 rtl/cdb_arbiter.sv | 112 +++++++++++
 tb/tb_cdb_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one pending result per cycle and registers the broadcast.
// Optional per-unit grant and conflict counters are compiled in when CDB_PERF_EN is defined.
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              cdb_stall,
  input  logic                              flush,
  output logic                              cdb_valid,
  output logic [TAG_W-1:0]                  cdb_tag,
  output logic [DATA_W-1:0]                 cdb_data,
  output logic [SRC_W-1:0]                  cdb_src
`ifdef CDB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]          perf_grants,
  output logic [31:0]                       perf_conflict
`endif
);

  localparam logic [SRC_W:0] NREQ      = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

  logic [SRC_W-1:0]  last_grant_reg;
  logic              cdb_valid_reg;
  logic [TAG_W-1:0]  cdb_tag_reg;
  logic [DATA_W-1:0] cdb_data_reg;
  logic [SRC_W-1:0]  cdb_src_reg;

  logic              grant_en;
  logic              found;
  logic              fire;
  logic [SRC_W-1:0]  grant_idx;
  logic [SRC_W:0]    cand;

  assign grant_en = !(cdb_stall || flush || rst);

  // Scan starting just after the last winner, wrapping around once.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, last_grant_reg} + (SRC_W+1)'(off);
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req_valid[cand[SRC_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[SRC_W-1:0];
      end
    end
  end

  assign fire      = grant_en && found;
  assign req_ready = fire ? (NUM_REQ'(1) << grant_idx) : '0;

  // Flush drops the valid but keeps the payload; stall freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= LAST_IDX;
      cdb_valid_reg  <= 1'b0;
      cdb_tag_reg    <= '0;
      cdb_data_reg   <= '0;
      cdb_src_reg    <= '0;
    end else if (flush) begin
      cdb_valid_reg  <= 1'b0;
    end else if (!cdb_stall) begin
      cdb_valid_reg  <= fire;
      if (fire) begin
        last_grant_reg <= grant_idx;
        cdb_tag_reg    <= req_tag[grant_idx];
        cdb_data_reg   <= req_data[grant_idx];
        cdb_src_reg    <= grant_idx;
      end
    end
  end

  assign cdb_valid = cdb_valid_reg;
  assign cdb_tag   = cdb_tag_reg;
  assign cdb_data  = cdb_data_reg;
  assign cdb_src   = cdb_src_reg;

`ifdef CDB_PERF_EN
  logic [31:0] grant_cnt_reg [NUM_REQ];
  logic [31:0] conflict_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
      always_ff @(posedge clk) begin
        if (rst) grant_cnt_reg[gi] <= '0;
        else if (req_ready[gi]) grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 32'd1;
      end
      assign perf_grants[gi] = grant_cnt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) conflict_cnt_reg <= '0;
    else if (fire && ($countones(req_valid) > 1)) conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
  end

  assign perf_conflict = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected broadcasts into a queue, a monitor pops and compares them.
module tb_cdb_arbiter;

  logic              clk;
  logic              rst;
  logic [2:0]        req_valid;
  logic [2:0][3:0]   req_tag;
  logic [2:0][31:0]  req_data;
  logic [2:0]        req_ready;
  logic              cdb_stall;
  logic              flush;
  logic              cdb_valid;
  logic [3:0]        cdb_tag;
  logic [31:0]       cdb_data;
  logic [1:0]        cdb_src;
`ifdef CDB_PERF_EN
  logic [2:0][31:0]  perf_grants;
  logic [31:0]       perf_conflict;
`endif

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready), .cdb_stall(cdb_stall), .flush(flush), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
`ifdef CDB_PERF_EN
    , .perf_grants(perf_grants), .perf_conflict(perf_conflict)
`endif
  );

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
    logic [1:0]  src;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  tags  [3];
  logic [31:0] datas [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  // One cycle: drive, check grant and broadcast-valid at the falling edge, queue the expected broadcast.
  task automatic step(input string name, input logic [2:0] v, input logic st, input logic fl,
                      input logic r, input logic [2:0] exp_rdy, input logic exp_cv);
    exp_t e;
    req_valid = v; cdb_stall = st; flush = fl; rst = r;
    for (int i = 0; i < 3; i++) begin
      req_tag[i]  = tags[i];
      req_data[i] = datas[i];
    end
    @(negedge clk);
    check({name, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
    check({name, " cdb_valid"}, 32'(cdb_valid), 32'(exp_cv));
    for (int i = 0; i < 3; i++) begin
      if (exp_rdy[i]) begin
        e.tag = tags[i]; e.data = datas[i]; e.src = 2'(i);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (cdb_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL cdb_unexpected: got tag=%0d src=%0d, required no broadcast", cdb_tag, cdb_src);
      end else begin
        if (cdb_tag !== exp_q[0].tag || cdb_data !== exp_q[0].data || cdb_src !== exp_q[0].src) begin
          n_bad++;
          $display("FAIL cdb_bcast: got tag=%0d data=0x%0h src=%0d, required tag=%0d data=0x%0h src=%0d",
                   cdb_tag, cdb_data, cdb_src, exp_q[0].tag, exp_q[0].data, exp_q[0].src);
        end else begin
          $display("bcast tag=%0d data=0x%0h src=%0d stall=%0b flush=%0b", cdb_tag, cdb_data, cdb_src, cdb_stall, flush);
        end
        if (!cdb_stall || flush) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    tags[0] = 4'd1; tags[1] = 4'd2; tags[2] = 4'd3;
    datas[0] = 32'hA; datas[1] = 32'hB; datas[2] = 32'hC;
    rst = 1'b1; req_valid = '0; req_tag = '0; req_data = '0; cdb_stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    // Reset state.
    step("reset", 3'b111, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    check("reset cdb_tag", 32'(cdb_tag), 32'd0);
    check("reset cdb_data", cdb_data, 32'd0);
    check("reset cdb_src", 32'(cdb_src), 32'd0);

    // All three valid: rotate 0,1,2,0.
    step("rr0", 3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0);
    step("rr1", 3'b111, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1);
    step("rr2", 3'b111, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1);
    step("rr3", 3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1);
    step("rr_tail", 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    step("rr_idle", 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

    // Lone LSQ request.
    tags[2] = 4'd7; datas[2] = 32'hDEAD_BEEF;
    step("lsq", 3'b100, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0);
    step("lsq_bc", 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    step("lsq_idle", 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

    // Tag 5 broadcast held through a 3-cycle stall, then grant resumes after index 0.
    tags[0] = 4'd5; datas[0] = 32'h55;
    step("pre_stall", 3'b001, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0);
    step("stall1", 3'b011, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    step("stall2", 3'b011, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    step("stall3", 3'b011, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    step("unstall", 3'b011, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1);

    // Flush with a broadcast live: no grant, valid drops, pointer stays at 1.
    step("flush", 3'b010, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
    step("post_flush", 3'b111, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0);
    step("post_flush2", 3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1);

    // Reset right after a fire: pointer returns so index 0 wins first.
    step("mid_reset", 3'b111, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1);
    step("after_reset", 3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0);
    step("after_reset_bc", 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    step("after_reset_idle", 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

`ifdef CDB_PERF_EN
    step("perf_reset", 3'b111, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    step("perf0", 3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0);
    step("perf1", 3'b111, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1);
    step("perf2", 3'b111, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1);
    step("perf3", 3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1);
    step("perf4", 3'b111, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1);
    step("perf5", 3'b111, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1);
    step("perf_tail", 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    check("perf_grants0", perf_grants[0], 32'd2);
    check("perf_grants1", perf_grants[1], 32'd2);
    check("perf_grants2", perf_grants[2], 32'd2);
    check("perf_conflict", perf_conflict, 32'd6);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
